// File: rtl/systolic_operand_feeder_pkg.sv
// systolic_pkg: shared defaults, feeder state encoding and wavefront length.
package systolic_pkg;
  localparam int N_DEF = 4;
  localparam int DW_DEF = 4;
  localparam int WAVE_LEN = 3 * N_DEF - 2;
  typedef enum logic [1:0] {LOAD, FEED, DONE} feed_state_t;
  function automatic int wave_len(input int n);
    return 3 * n - 2;
  endfunction
endpackage

// File: rtl/systolic_operand_feeder_if.sv
// systolic_operand_feeder_if: operand streams in, skewed array edges out.
interface systolic_operand_feeder_if import systolic_pkg::*; #(parameter int N = N_DEF, parameter int DW = DW_DEF);
  logic a_valid, a_ready, b_valid, b_ready, feed_active, done;
  logic [N*DW-1:0] a_row, b_col, m_edge, n_edge;
  modport master(output a_valid, a_row, b_valid, b_col,
                 input a_ready, b_ready, m_edge, n_edge, feed_active, done);
  modport slave(input a_valid, a_row, b_valid, b_col,
                output a_ready, b_ready, m_edge, n_edge, feed_active, done);
endinterface

// File: rtl/systolic_operand_feeder_operand_bank.sv
// operand_bank: N-slot operand buffer with write counter and a diagonal skewed read port.
module operand_bank #(parameter int N = 4, parameter int DW = 4, parameter int TW = 4) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  input  logic            valid,
  input  logic [N*DW-1:0] din,
  input  logic [TW-1:0]   t,
  output logic            ready,
  output logic            full_nxt,
  output logic [N*DW-1:0] rd
);
  localparam int CW = $clog2(N + 1);
  localparam int AW = $clog2(N);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N*DW-1:0] mem_q [N];
  logic [N*DW-1:0] mem_d [N];
  logic acc;
  always_comb begin
    ready = en && cnt_q != CW'(N);
    acc = valid && ready;
    full_nxt = cnt_q == CW'(N) || (acc && cnt_q == CW'(N - 1));
    cnt_d = clr ? '0 : cnt_q + CW'(acc);
    mem_d = mem_q;
    if (acc) mem_d[cnt_q[AW-1:0]] = din;
    rd = '0;
    // slot i feeds lane i; element t-i is in the window only for 0 <= t-i < N
    for (int i = 0; i < N; i++)
      if (t >= TW'(i) && t - TW'(i) < TW'(N)) rd[i*DW +: DW] = mem_q[i][(t - TW'(i))*DW +: DW];
  end
  always_ff @(posedge clk) begin
    cnt_q <= rst ? '0 : cnt_d;
    mem_q <= mem_d;
  end
endmodule

// File: rtl/systolic_operand_feeder.sv
// systolic_operand_feeder: buffers A rows and B columns, then issues the skewed zero-padded wavefront.
module systolic_operand_feeder import systolic_pkg::*; #(parameter int N = N_DEF, parameter int DW = DW_DEF) (
  input logic clk,
  input logic rst,
  systolic_operand_feeder_if.slave io
);
  localparam int TW = $clog2(3 * N);
  localparam logic [TW-1:0] LAST_T = TW'(wave_len(N) - 1);
  feed_state_t state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [N*DW-1:0] m_q, m_d, n_q, n_d, a_rd, b_rd;
  logic a_fn, b_fn, last, en, clr;
  operand_bank #(.N(N), .DW(DW), .TW(TW)) a_bank (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .valid(io.a_valid), .din(io.a_row),
    .t(t_d), .ready(io.a_ready), .full_nxt(a_fn), .rd(a_rd));
  operand_bank #(.N(N), .DW(DW), .TW(TW)) b_bank (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .valid(io.b_valid), .din(io.b_col),
    .t(t_d), .ready(io.b_ready), .full_nxt(b_fn), .rd(b_rd));
  // edges are registered from the next wave index so they line up with t_q
  always_comb begin
    en = state_q == LOAD && !rst;
    last = t_q == LAST_T;
    state_d = state_q == LOAD ? (a_fn && b_fn ? FEED : LOAD) :
              state_q == FEED ? (last ? DONE : FEED) : LOAD;
    t_d = (state_q == FEED && !last) ? t_q + 1'b1 : '0;
    clr = state_d == DONE;
    m_d = state_d == FEED ? a_rd : '0;
    n_d = state_d == FEED ? b_rd : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      t_q <= '0;
      m_q <= '0;
      n_q <= '0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      m_q <= m_d;
      n_q <= n_d;
    end
  end
  assign io.m_edge = m_q;
  assign io.n_edge = n_q;
  assign io.feed_active = state_q == FEED;
  assign io.done = state_q == DONE;
endmodule

// File: tb/tb_systolic_operand_feeder.sv
// tb_systolic_operand_feeder: table vectors plus scoreboard against a reference skew model.
module tb_systolic_operand_feeder;
  import systolic_pkg::*;
  localparam int N = 4, DW = 4, W = N * DW;
  typedef struct {logic [W-1:0] m, n;} exp_t;
  typedef struct {int t; logic [W-1:0] m, n;} vec_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  systolic_operand_feeder_if #(.N(N), .DW(DW)) io();
  systolic_operand_feeder #(.N(N), .DW(DW)) dut(.clk(clk), .rst(rst), .io(io));
  int total = 0, bad = 0, a_hs = 0, b_hs = 0, a0, b0;
  logic [DW-1:0] am [N][N];
  logic [DW-1:0] bm [N][N];
  logic [W-1:0] got_m [WAVE_LEN];
  logic [W-1:0] got_n [WAVE_LEN];
  exp_t q[$];
  vec_t tab [WAVE_LEN];
  always @(posedge clk) begin
    if (io.a_valid && io.a_ready) a_hs++;
    if (io.b_valid && io.b_ready) b_hs++;
  end
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h @%0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] row_of(input int r);
    logic [W-1:0] v = '0;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = am[r][k];
    return v;
  endfunction
  function automatic logic [W-1:0] col_of(input int c);
    logic [W-1:0] v = '0;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = bm[k][c];
    return v;
  endfunction
  function automatic logic [W-1:0] model_m(input int t);
    logic [W-1:0] v = '0;
    for (int i = 0; i < N; i++) if (t - i >= 0 && t - i < N) v[i*DW +: DW] = am[i][t-i];
    return v;
  endfunction
  function automatic logic [W-1:0] model_n(input int t);
    logic [W-1:0] v = '0;
    for (int j = 0; j < N; j++) if (t - j >= 0 && t - j < N) v[j*DW +: DW] = bm[t-j][j];
    return v;
  endfunction
  task automatic rand_mats();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        am[r][c] = DW'($urandom);
        bm[r][c] = DW'($urandom);
      end
  endtask
  task automatic do_reset();
    rst = 1;
    io.a_valid = 0;
    io.b_valid = 0;
    io.a_row = '0;
    io.b_col = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", io.a_ready, 0);
    chk("rst_b_ready", io.b_ready, 0);
    chk("rst_m_edge", io.m_edge, 0);
    chk("rst_n_edge", io.n_edge, 0);
    chk("rst_feed", io.feed_active, 0);
    chk("rst_done", io.done, 0);
    rst = 0;
  endtask
  task automatic load(input int ad, input int bd, input bit rnd, input bit hold);
    int ai = 0, bi = 0, cyc = 0;
    bit acc_a, acc_b;
    a0 = a_hs;
    b0 = b_hs;
    @(posedge clk); #1;
    while ((ai < N || bi < N) && cyc < 200) begin
      io.a_valid = ai < N ? (cyc >= ad && (!rnd || $urandom_range(1, 0) == 1)) : hold;
      io.b_valid = bi < N ? (cyc >= bd && (!rnd || $urandom_range(1, 0) == 1)) : hold;
      io.a_row = row_of(ai < N ? ai : 0);
      io.b_col = col_of(bi < N ? bi : 0);
      @(negedge clk);
      if (cyc == 0) begin
        chk("load_a_ready", io.a_ready, 1);
        chk("load_b_ready", io.b_ready, 1);
      end
      if (ai >= N && hold) chk("a_ready_held", io.a_ready, 0);
      if (bi >= N && hold) chk("b_ready_held", io.b_ready, 0);
      acc_a = io.a_valid && io.a_ready;
      acc_b = io.b_valid && io.b_ready;
      @(posedge clk); #1;
      ai += int'(acc_a);
      bi += int'(acc_b);
      cyc++;
    end
    if (cyc >= 200) begin
      total++;
      bad++;
      $display("FAIL load_timeout a=%0d b=%0d", ai, bi);
    end
    io.a_valid = hold;
    io.b_valid = hold;
    for (int t = 0; t < WAVE_LEN; t++) q.push_back('{model_m(t), model_n(t)});
    chk("feed_start", io.feed_active, 1);
  endtask
  task automatic run_feed(input int abort_t);
    exp_t e;
    for (int t = 0; t < WAVE_LEN; t++) begin
      @(negedge clk);
      e = q.pop_front();
      got_m[t] = io.m_edge;
      got_n[t] = io.n_edge;
      chk("m_edge", io.m_edge, e.m);
      chk("n_edge", io.n_edge, e.n);
      chk("feed_active", io.feed_active, 1);
      chk("done_early", io.done, 0);
      chk("feed_a_ready", io.a_ready, 0);
      chk("feed_b_ready", io.b_ready, 0);
      if (t == abort_t) begin
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("abort_m", io.m_edge, 0);
        chk("abort_n", io.n_edge, 0);
        chk("abort_feed", io.feed_active, 0);
        chk("abort_a_ready", io.a_ready, 1);
        chk("abort_b_ready", io.b_ready, 1);
        repeat (WAVE_LEN) begin
          @(negedge clk);
          chk("abort_no_done", io.done, 0);
        end
        q.delete();
        return;
      end
    end
    @(negedge clk);
    chk("done_pulse", io.done, 1);
    chk("done_feed", io.feed_active, 0);
    chk("done_m", io.m_edge, 0);
    chk("done_n", io.n_edge, 0);
    chk("done_a_ready", io.a_ready, 0);
    chk("done_b_ready", io.b_ready, 0);
  endtask
  initial begin
    tab[0] = '{0, 16'h0001, 16'h0001};
    tab[1] = '{1, 16'h0052, 16'h0000};
    tab[2] = '{2, 16'h0963, 16'h0010};
    tab[3] = '{3, 16'hDA74, 16'h0000};
    tab[4] = '{4, 16'hEB80, 16'h0100};
    tab[5] = '{5, 16'hFC00, 16'h0000};
    tab[6] = '{6, 16'h0000, 16'h1000};
    tab[7] = '{7, 16'h0000, 16'h0000};
    tab[8] = '{8, 16'h0000, 16'h0000};
    tab[9] = '{9, 16'h0000, 16'h0000};
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        am[r][c] = DW'(4 * r + c + 1);
        bm[r][c] = DW'(r == c);
      end
    do_reset();
    load(0, 0, 0, 0);
    run_feed(-1);
    for (int i = 0; i < WAVE_LEN; i++) begin
      chk("tab_m", got_m[tab[i].t], tab[i].m);
      chk("tab_n", got_n[tab[i].t], tab[i].n);
    end
    chk("beats_a", W'(a_hs - a0), 4);
    chk("beats_b", W'(b_hs - b0), 4);
    rand_mats();
    load(0, 9, 0, 1);
    run_feed(-1);
    chk("late_b_beats_a", W'(a_hs - a0), 4);
    chk("late_b_beats_b", W'(b_hs - b0), 4);
    rand_mats();
    load(0, 0, 1, 0);
    run_feed(-1);
    for (int k = 0; k < 2; k++) begin
      rand_mats();
      load(0, 0, 0, 1);
      run_feed(-1);
      chk("b2b_beats_a", W'(a_hs - a0), 4);
      chk("b2b_beats_b", W'(b_hs - b0), 4);
    end
    io.a_valid = 0;
    io.b_valid = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        am[r][c] = '1;
        bm[r][c] = '1;
      end
    load(0, 0, 0, 0);
    run_feed(-1);
    rand_mats();
    load(0, 0, 0, 0);
    run_feed(5);
    rand_mats();
    load(0, 0, 1, 0);
    run_feed(-1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
